spi_rx_tx_fifo: RTL and testbench

SPI_RX_TX_FIFO -- requirements
Module: spi_rx_tx_fifo

---
 rtl/spi_rx_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_spi_rx_tx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_tx_fifo.sv
// ----------------------------------------------------------------------------
// spi_rx_tx_fifo
// Synchronous single-clock FIFO used to buffer SPI receive/transmit words.
// It provides occupancy flags, sticky overflow/underflow error bits, and two
// read modes: registered read (FWFT=0) and first-word-fall-through (FWFT=1).
//
// Ports
//   clk          in   clock, all logic on posedge
//   reset        in   synchronous, active-high; highest priority
//   flush        in   synchronous clear of contents, pointers and error flags
//   wr_en        in   write request
//   data_in      in   write data [DATA_WIDTH]
//   rd_en        in   read/pop request
//   data_out     out  read data [DATA_WIDTH]
//   rd_valid     out  data_out holds a newly read word (FWFT=0) / !empty (FWFT=1)
//   full         out  level == DEPTH
//   empty        out  level == 0
//   almost_full  out  level >= AF_LEVEL
//   almost_empty out  level <= AE_LEVEL
//   level        out  current occupancy [$clog2(DEPTH)+1]
//   overflow     out  sticky: write rejected while full
//   underflow    out  sticky: read rejected while empty
// ----------------------------------------------------------------------------
module spi_rx_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // Storage carries no reset; outputs only ever read entries that were written.
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_dout;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [DATA_WIDTH-1:0] w_head;

   always_comb begin
      w_full   = (r_level == LW'(DEPTH));
      w_empty  = (r_level == '0);
      w_rd_acc = rd_en && !w_empty && !flush;
      // A full FIFO still takes a write when a read frees a slot the same cycle.
      w_wr_acc = wr_en && !flush && (!w_full || w_rd_acc);
      w_head   = r_mem[r_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!reset && w_wr_acc) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_dout      <= '0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_rd_valid  <= 1'b0;
         // In FWFT mode the visible word is the live head; capture it so
         // data_out holds across the flush instead of reverting to an older value.
         if (FWFT != 0 && !w_empty) begin
            r_dout <= w_head;
         end
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_dout   <= w_head;
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         if (wr_en && w_full && !w_rd_acc) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
         r_rd_valid <= w_rd_acc;
      end
   end

   always_comb begin
      full         = w_full;
      empty        = w_empty;
      almost_full  = (r_level >= LW'(AF_LEVEL));
      almost_empty = (r_level <= LW'(AE_LEVEL));
      level        = r_level;
      overflow     = r_overflow;
      underflow    = r_underflow;
      // FWFT: the head is shown while data exists; when empty, the last
      // popped/captured word is held.
      if (FWFT != 0) begin
         data_out = w_empty ? r_dout : w_head;
         rd_valid = !w_empty;
      end else begin
         data_out = r_dout;
         rd_valid = r_rd_valid;
      end
   end

endmodule

// File: tb/tb_spi_rx_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_spi_rx_tx_fifo
// Self-checking bench for spi_rx_tx_fifo. Two instances share stimulus:
// u0 uses registered read (FWFT=0), u1 uses first-word-fall-through (FWFT=1).
// ----------------------------------------------------------------------------
module tb_spi_rx_tx_fifo;

   logic       clk = 1'b0;
   logic       reset, flush, wr_en, rd_en;
   logic [7:0] data_in;

   logic [7:0] d0, d1;
   logic       rv0, rv1, fu0, fu1, em0, em1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
   logic [4:0] lv0, lv1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spi_rx_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u0 (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(d0), .rd_valid(rv0), .full(fu0), .empty(em0),
      .almost_full(af0), .almost_empty(ae0), .level(lv0), .overflow(ov0),
      .underflow(un0));

   spi_rx_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u1 (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(d1), .rd_valid(rv1), .full(fu1), .empty(em1),
      .almost_full(af1), .almost_empty(ae1), .level(lv1), .overflow(ov1),
      .underflow(un1));

   typedef struct {
      logic       rst, fl, we, re;
      logic [7:0] din;
      int         lvl;
      logic       emp, ful, afl, ael, ov, un, rv;
      logic       chk_d;
      logic [7:0] dout;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(logic rst, logic fl, logic we, logic [7:0] din, logic re,
                               int lvl, logic ov, logic un, logic rv, logic [7:0] dout);
      vec_t v;
      v.rst = rst; v.fl = fl; v.we = we; v.din = din; v.re = re;
      v.lvl = lvl; v.emp = (lvl == 0); v.ful = (lvl == 16);
      v.afl = (lvl >= 14); v.ael = (lvl <= 2);
      v.ov = ov; v.un = un; v.rv = rv; v.chk_d = 1'b1; v.dout = dout;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic we,
                        input logic [7:0] din, input logic re);
      reset = rst; flush = fl; wr_en = we; data_in = din; rd_en = re;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks u0 flags/level against the occupancy the bench expects.
   task automatic chk_lvl0(input string nm, input int lvl);
      chk({nm, ".level"}, int'(lv0), lvl);
      chk({nm, ".empty"}, int'(em0), int'(lvl == 0));
      chk({nm, ".full"},  int'(fu0), int'(lvl == 16));
      chk({nm, ".afull"}, int'(af0), int'(lvl >= 14));
      chk({nm, ".aempty"},int'(ae0), int'(lvl <= 2));
   endtask

   task automatic chk_reset0(input string nm);
      chk_lvl0(nm, 0);
      chk({nm, ".dout"}, int'(d0), 0);
      chk({nm, ".rv"},   int'(rv0), 0);
      chk({nm, ".ovf"},  int'(ov0), 0);
      chk({nm, ".udf"},  int'(un0), 0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] e;
      int         lvl_m, nw;
      logic       up;
      logic [7:0] nextd;

      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step();

      // -------- table-driven basic sequence on u0 --------
      vt[0]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
      vt[1]  = mk(0, 0, 1, 8'h11, 0, 1, 0, 0, 0, 8'h00);
      vt[2]  = mk(0, 0, 1, 8'h22, 0, 2, 0, 0, 0, 8'h00);
      vt[3]  = mk(0, 0, 1, 8'h33, 0, 3, 0, 0, 0, 8'h00);
      vt[4]  = mk(0, 0, 0, 8'h00, 1, 2, 0, 0, 1, 8'h11);
      vt[5]  = mk(0, 0, 0, 8'h00, 0, 2, 0, 0, 0, 8'h11);
      vt[6]  = mk(0, 0, 1, 8'h44, 1, 2, 0, 0, 1, 8'h22);
      vt[7]  = mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h33);
      vt[8]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h44);
      vt[9]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 8'h44);
      vt[10] = mk(0, 0, 1, 8'h5A, 1, 1, 0, 1, 0, 8'h44);
      vt[11] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h5A);
      vt[12] = mk(0, 1, 1, 8'h77, 1, 0, 0, 0, 0, 8'h5A);
      vt[13] = mk(1, 0, 1, 8'h88, 1, 0, 0, 0, 0, 8'h00);

      for (int i = 0; i < 14; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         drive(vt[i].rst, vt[i].fl, vt[i].we, vt[i].din, vt[i].re);
         step();
         chk({nm, ".level"}, int'(lv0), vt[i].lvl);
         chk({nm, ".empty"}, int'(em0), int'(vt[i].emp));
         chk({nm, ".full"},  int'(fu0), int'(vt[i].ful));
         chk({nm, ".afull"}, int'(af0), int'(vt[i].afl));
         chk({nm, ".aempty"},int'(ae0), int'(vt[i].ael));
         chk({nm, ".ovf"},   int'(ov0), int'(vt[i].ov));
         chk({nm, ".udf"},   int'(un0), int'(vt[i].un));
         chk({nm, ".rv"},    int'(rv0), int'(vt[i].rv));
         if (vt[i].chk_d) chk({nm, ".dout"}, int'(d0), int'(vt[i].dout));
      end

      // -------- fill 16, drain 16 in order --------
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); step();
      chk_reset0("rst_a");
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0); step();
         chk_lvl0($sformatf("fill%0d", i), i);
      end
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
         chk($sformatf("drain%0d.rv", i),   int'(rv0), 1);
         chk($sformatf("drain%0d.dout", i), int'(d0), i);
         chk_lvl0($sformatf("drain%0d", i), 16 - i);
      end

      // -------- overflow on full, then simultaneous read+write on full --------
      for (int i = 1; i <= 16; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0); step();
      end
      chk_lvl0("refill", 16);
      drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0); step();
      chk("ovf.set", int'(ov0), 1);
      chk_lvl0("ovf", 16);
      chk("ovf.rv", int'(rv0), 0);
      drive(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1); step();
      chk_lvl0("fullrw", 16);
      chk("fullrw.dout", int'(d0), 1);
      chk("fullrw.rv", int'(rv0), 1);
      for (int i = 2; i <= 17; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
         chk($sformatf("odrain%0d.dout", i), int'(d0), (i == 17) ? 32'hBB : i);
      end
      chk_lvl0("odrain_end", 0);
      chk("ovf.sticky", int'(ov0), 1);

      // -------- 40 interleaved writes/reads with wrap --------
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); step();
      lvl_m = 0; nw = 0; up = 1'b1; nextd = 8'h80;
      for (int c = 0; c < 200 && (nw < 40 || lvl_m > 0); c++) begin
         if (up && lvl_m == 15) up = 1'b0;
         else if (!up && lvl_m == 1 && nw < 40) up = 1'b1;
         if (nw >= 40) up = 1'b0;
         if (up) begin
            drive(1'b0, 1'b0, 1'b1, nextd, 1'b0);
            q.push_back(nextd);
            nextd++; nw++; lvl_m++;
            step();
            chk($sformatf("il%0d.rv", c), int'(rv0), 0);
         end else begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            e = q.pop_front();
            lvl_m--;
            step();
            chk($sformatf("il%0d.rv", c),   int'(rv0), 1);
            chk($sformatf("il%0d.dout", c), int'(d0), int'(e));
         end
         chk_lvl0($sformatf("il%0d", c), lvl_m);
      end
      chk("il.writes", nw, 40);

      // -------- flush at level 5 with overflow set --------
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); step();
      for (int i = 1; i <= 17; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0); step();
      end
      for (int i = 0; i < 11; i++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      end
      chk_lvl0("pre_flush", 5);
      chk("pre_flush.ovf", int'(ov0), 1);
      chk("pre_flush.dout", int'(d0), 8'h2B);
      drive(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1); step();
      chk_lvl0("flush", 0);
      chk("flush.ovf",  int'(ov0), 0);
      chk("flush.rv",   int'(rv0), 0);
      chk("flush.dout", int'(d0), 8'h2B);

      // -------- reset at level 9 --------
      for (int i = 1; i <= 9; i++) begin
         drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0); step();
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      drive(1'b0, 1'b0, 1'b1, 8'h4A, 1'b0); step();
      chk_lvl0("pre_rst", 9);
      chk("pre_rst.dout", int'(d0), 8'h41);
      drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b1); step();
      chk_reset0("mid_rst");

      // -------- FWFT instance --------
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); step();
      chk("fw.rst.dout", int'(d1), 0);
      chk("fw.rst.rv",   int'(rv1), 0);
      chk("fw.rst.empty",int'(em1), 1);
      drive(1'b0, 1'b0, 1'b1, 8'h33, 1'b0); step();
      chk("fw.wr.dout",  int'(d1), 8'h33);
      chk("fw.wr.rv",    int'(rv1), 1);
      chk("fw.wr.empty", int'(em1), 0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      chk("fw.rd.empty", int'(em1), 1);
      chk("fw.rd.rv",    int'(rv1), 0);
      drive(1'b0, 1'b0, 1'b1, 8'h44, 1'b0); step();
      drive(1'b0, 1'b0, 1'b1, 8'h55, 1'b0); step();
      chk("fw.two.dout", int'(d1), 8'h44);
      chk("fw.two.level",int'(lv1), 2);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      chk("fw.pop1.dout",int'(d1), 8'h55);
      chk("fw.pop1.rv",  int'(rv1), 1);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      chk("fw.pop2.empty", int'(em1), 1);
      chk("fw.pop2.rv",    int'(rv1), 0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1); step();
      chk("fw.udf", int'(un1), 1);

      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
